// File: rtl/seq_pattern_detector_if.sv
// Serial pattern detector bus: stream, configuration and result signals.
// clk and reset stay plain ports on the detector itself.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               a;
  logic               a_valid;
  logic               load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               ovl_in;
  logic               clr_cnt;
  logic               w;
  logic [CNT_W-1:0]   count;
  logic               cfg_err;

  modport master (
    output a, a_valid, load,
    output pat_in, len_in, ovl_in,
    output clr_cnt,
    input  w, count, cfg_err
  );

  modport slave (
    input  a, a_valid, load,
    input  pat_in, len_in, ovl_in,
    input  clr_cnt,
    output w, count, cfg_err
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-loadable serial pattern detector with overlap control
// and a saturating match counter; resets to "101" with overlap.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic reset,
  seq_pattern_detector_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(3);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(3'b101);

  logic [MAX_LEN-1:0] pat, pat_n;
  logic [LEN_W-1:0]   len, len_n;
  logic               ovl, ovl_n;
  logic [MAX_LEN-1:0] hist, hist_n;
  logic [LEN_W-1:0]   fill, fill_n;
  logic               w_q, w_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_q, err_n;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;
  logic               legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat   <= PAT_RST;
      len   <= LEN_RST;
      ovl   <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      w_q   <= 1'b0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      pat   <= pat_n;
      len   <= len_n;
      ovl   <= ovl_n;
      hist  <= hist_n;
      fill  <= fill_n;
      w_q   <= w_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    shifted  = {hist[MAX_LEN-2:0], bus.a};
    fill_inc = (fill < len) ? fill + LEN_W'(1) : len;
    mask     = '0;
    // only the low len bits of the history take part in the compare
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hit   = bus.a_valid && !bus.load &&
            (fill_inc == len) &&
            (((shifted ^ pat) & mask) == '0);
    legal = (bus.len_in != '0) && (bus.len_in <= LEN_MAX);
  end

  always_comb begin
    pat_n  = pat;
    len_n  = len;
    ovl_n  = ovl;
    hist_n = hist;
    fill_n = fill;
    w_n    = 1'b0;
    cnt_n  = cnt;
    err_n  = 1'b0;

    if (bus.load) begin
      if (legal) begin
        pat_n  = bus.pat_in;
        len_n  = bus.len_in;
        ovl_n  = bus.ovl_in;
        hist_n = '0;
        fill_n = '0;
      end else begin
        err_n = 1'b1;
      end
    end else if (bus.a_valid) begin
      hist_n = shifted;
      fill_n = (hit && !ovl) ? '0 : fill_inc;
      w_n    = hit;
    end

    if (bus.clr_cnt) begin
      cnt_n = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt != '1)) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  assign bus.w       = w_q;
  assign bus.count   = cnt;
  assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed, table-driven bench for seq_pattern_detector.
// Each row is one clock: inputs plus the outputs expected after it.
module tb_seq_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  typedef struct {
    bit       rst;
    bit       ld;
    bit [7:0] pat;
    bit [3:0] len;
    bit       ovl;
    bit       av;
    bit       a;
    bit       clr;
    bit       ew;
    int       ecnt;
    bit       eerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  vec_t tbl[$];

  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(bit r, bit l, bit [7:0] p, bit [3:0] n,
                              bit o, bit v, bit d, bit c,
                              bit ew, int ec, bit ee);
    vec_t t;
    t.rst = r; t.ld = l; t.pat = p; t.len = n; t.ovl = o;
    t.av = v; t.a = d; t.clr = c;
    t.ew = ew; t.ecnt = ec; t.eerr = ee;
    tbl.push_back(t);
  endfunction

  function automatic void rs();
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void sb(bit d, bit ew, int ec);
    add(0, 0, 8'h00, 0, 0, 1, d, 0, ew, ec, 0);
  endfunction

  function automatic void gap(int ec);
    add(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, ec, 0);
  endfunction

  function automatic void ld(bit [7:0] p, bit [3:0] n, bit o,
                             bit v, bit d, bit ee, int ec);
    add(0, 1, p, n, o, v, d, 0, 0, ec, ee);
  endfunction

  function automatic vec_t mk(bit v, bit d, bit c, bit ew, int ec);
    vec_t t;
    t.rst = 0; t.ld = 0; t.pat = 0; t.len = 0; t.ovl = 0;
    t.av = v; t.a = d; t.clr = c;
    t.ew = ew; t.ecnt = ec; t.eerr = 0;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag, input int idx);
    reset       = t.rst;
    bus.load    = t.ld;
    bus.pat_in  = t.pat;
    bus.len_in  = t.len;
    bus.ovl_in  = t.ovl;
    bus.a_valid = t.av;
    bus.a       = t.a;
    bus.clr_cnt = t.clr;
    @(posedge clk);
    #1;
    checks++;
    if (bus.w === t.ew) passed++;
    else $display("FAIL %s[%0d] w: got %b want %b", tag, idx, bus.w, t.ew);
    checks++;
    if (bus.count === CNT_W'(t.ecnt)) passed++;
    else $display("FAIL %s[%0d] count: got %0d want %0d",
                  tag, idx, bus.count, t.ecnt);
    checks++;
    if (bus.cfg_err === t.eerr) passed++;
    else $display("FAIL %s[%0d] cfg_err: got %b want %b",
                  tag, idx, bus.cfg_err, t.eerr);
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 0; bus.pat_in = 0; bus.len_in = 0; bus.ovl_in = 0;
    bus.a_valid = 0; bus.a = 0; bus.clr_cnt = 0;

    // default 101 with overlap
    rs();
    sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1); sb(0, 0, 1); sb(1, 1, 2);

    // non-overlap 101
    rs();
    ld(8'h05, 3, 0, 0, 0, 0, 0);
    sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1); sb(0, 0, 1);
    sb(1, 0, 1); sb(0, 0, 1); sb(1, 1, 2);

    // overlap reference on the same stream
    rs();
    sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1); sb(0, 0, 1);
    sb(1, 1, 2); sb(0, 0, 2); sb(1, 1, 3);

    // A5 over 8 bits with a two-cycle valid gap
    rs();
    ld(8'hA5, 8, 1, 0, 0, 0, 0);
    sb(1, 0, 0); sb(0, 0, 0); sb(1, 0, 0); sb(0, 0, 0);
    gap(0); gap(0);
    sb(0, 0, 0); sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1);

    // reset mid-stream drops the loaded pattern and the count
    sb(1, 0, 1); sb(0, 0, 1);
    rs();
    sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1);

    // illegal loads: bit in the same cycle is dropped
    rs();
    ld(8'hFF, 0, 0, 1, 1, 1, 0);
    ld(8'h00, 9, 0, 1, 1, 1, 0);
    gap(0);
    sb(0, 0, 0); sb(1, 0, 0); sb(0, 0, 0); sb(1, 1, 1);

    foreach (tbl[i]) apply(tbl[i], "tbl", i);

    // single-bit pattern, saturation and clear
    tbl.delete();
    rs();
    ld(8'h01, 1, 1, 0, 0, 0, 0);
    foreach (tbl[i]) apply(tbl[i], "sat_setup", i);
    for (int i = 0; i < 300; i++) begin
      apply(mk(1, 1, 0, 1, (i + 1 > 255) ? 255 : i + 1), "sat", i);
    end
    apply(mk(1, 1, 1, 1, 1), "clr_hit", 0);
    apply(mk(0, 0, 1, 0, 0), "clr_idle", 0);
    apply(mk(1, 1, 0, 1, 1), "after_clr", 0);
    apply(mk(1, 0, 0, 0, 1), "zero_bit", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector: the next generation of the fixed 3-state "101" detector. Samples a single-bit stream under a valid qualifier and compares it against a runtime-loadable pattern of 1..MAX_LEN bits. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. Sits directly behind serial front-end logic; out of reset it detects "101" with overlap, as the fixed-pattern detector does.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥ 2).
- CNT_W, 8: match counter width.
- LEN_W (derived localparam): $clog2(MAX_LEN+1); 4 at default.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- a  in  1  serial data bit.
- a_valid  in  1  a is sampled only when high.
- load  in  1  one-cycle strobe; loads pat_in, len_in and ovl_in.
- pat_in  in  MAX_LEN  pattern. Bit len-1 is the first bit received; bit 0 is the last bit received.
- len_in  in  LEN_W  pattern length; legal range is 1..MAX_LEN.
- ovl_in  in  1  1 = overlapping matches, 0 = non-overlapping.
- clr_cnt  in  1  clears the match counter.
- w  out  1  registered one-cycle match pulse.
- count  out  CNT_W  saturating number of matches.
- cfg_err  out  1  registered one-cycle pulse on an illegal load.

## Operation
- Internal state:
  - pat, len, ovl: configuration.
  - hist[MAX_LEN-1:0]: shift history; newest bit in hist[0].
  - fill[LEN_W-1:0]: valid bits accumulated toward a match, saturating at len.
- Reset values:
  - pat = 101 zero-extended, len = 3, ovl = 1.
  - hist = 0, fill = 0.
  - w = 0, count = 0, cfg_err = 0.
- Priority per edge: reset, then load, then a_valid.
- load with a legal len_in (1..MAX_LEN):
  - Update pat, len and ovl.
  - Clear hist and fill; w = 0.
  - count is unchanged.
  - An a_valid bit in the same cycle is dropped.
- load with len_in = 0 or len_in > MAX_LEN:
  - Configuration, hist and fill are unchanged.
  - cfg_err = 1 for one cycle; w = 0.
  - The a_valid bit in the same cycle is dropped.
- a_valid = 1 with no load:
  - hist_n = {hist[MAX_LEN-2:0], a}; fill_n = min(fill+1, len).
  - Match condition: fill_n == len and hist_n[len-1:0] == pat[len-1:0]. Pattern bits at or above len are don't-care.
  - On a match: w = 1 on the next cycle; count increments, saturating at 2^CNT_W−1.
  - On a match with ovl = 0: fill is set to 0, so the next match needs len fresh bits.
  - On a match with ovl = 1: fill stays at len.
- a_valid = 0: hist and fill hold; w = 0.
- clr_cnt:
  - count is set to 0.
  - If a match occurs in the same cycle, count is set to 1.
  - clr_cnt has no effect on hist, fill or w.
- Configuration changes take effect only through load. ovl_in, pat_in and len_in are ignored otherwise.

## Timing
- w, count and cfg_err are all registered. Each updates on the edge that samples the final pattern bit (or the load), and is visible for the following cycle.
- Match latency: 1 clock from the last bit's sampling edge to w high.
- w is high for exactly one cycle per match.
- With a_valid held high in overlap mode, consecutive matches may pulse w on back-to-back cycles. Example: len = 1, or a pattern such as 11 on a run of ones.
- Gaps in a_valid stretch the stream without breaking a partial match.
- Reset mid-stream:
  - The next cycle has w = 0 and count = 0.
  - The configuration returns to 101/overlap; a previously loaded pattern is lost.
  - No match completes from bits received before reset.
- The first match after reset or load requires at least len valid bits.

## Test plan
- Default 101 detection after reset:
  - Stimulus: a = 1,0,1,0,1 with a_valid = 1 every cycle.
  - Required: w pulses the cycle after the 3rd and 5th bits; count = 2.
- Non-overlap mode:
  - Stimulus: load pat = 101, len = 3, ovl_in = 0; then a = 1,0,1,0,1,0,1.
  - Required: w pulses after bits 3 and 7 only; count = 2.
  - Overlap reference: the same stream with ovl = 1 gives pulses after bits 3, 5 and 7; count = 3.
- Full-length pattern with valid gaps:
  - Stimulus: load pat = 8'hA5, len = 8; send 10100101 with a_valid low for 2 cycles between bits 4 and 5.
  - Required: exactly one w pulse, one cycle after the 8th bit; no pulse during the gap.
- Illegal load:
  - Stimulus: load with len_in = 0, then len_in = 9 (at MAX_LEN = 8).
  - Required: cfg_err pulses each time; configuration stays 101/overlap; the following 1,0,1 still matches.
- Counter behaviour:
  - Stimulus: len = 1, pat = 1, stream of 300 ones; then clr_cnt asserted on a matching cycle.
  - Required: count saturates at 255; after clr_cnt, count = 1.
- Reset mid-stream:
  - Stimulus: after 1,0 assert reset for one cycle; then send 1.
  - Required: no w pulse; count = 0; a subsequent 0,1 is also needed, and 1,0,1 from there yields one pulse.
